fetch_target_queue: RTL and testbench
=====================================

FETCH_TARGET_QUEUE -- requirements
Module: fetch_target_queue

Interface
REQ-001 Parameter PLEN, default 32: physical address width.
REQ-002 Parameter SLOT_IDX_W, default 2: width of predicted-slot index.
REQ-003 Parameter DEPTH, default 8: queue entries; SHALL be a power of two and at least 2.
REQ-004 Parameter RESET_PC, default 32'h8000_0000: fetch PC after reset.
REQ-005 clk_i  in  1  single clock, all state on rising edge.
REQ-006 rst_ni  in  1  asynchronous active-low reset.
REQ-007 fetch_pc_o  out  PLEN  current fetch-block PC presented to the branch predictor.
REQ-008 bpu_npc_i  in  PLEN  predictor next PC for fetch_pc_o.
REQ-009 bpu_slot_valid_i / bpu_slot_idx_i / bpu_slot_target_i  in  1 / SLOT_IDX_W / PLEN  predictor taken-slot info for fetch_pc_o.
REQ-010 enq_valid_i  in  1  predictor result for fetch_pc_o is valid.
REQ-011 enq_ready_o  out  1  queue accepts the current prediction.
REQ-012 deq_valid_o  out  1  head entry available to the fetch unit.
REQ-013 deq_ready_i  in  1  fetch unit consumes the head entry.
REQ-014 deq_pc_o / deq_slot_valid_o / deq_slot_idx_o / deq_slot_target_o  out  PLEN / 1 / SLOT_IDX_W / PLEN  head entry fields.
REQ-015 deq_ftq_idx_o  out  log2(DEPTH)  storage index of the head entry.
REQ-016 redirect_valid_i  in  1  backend/fetch redirect, flushes the queue.
REQ-017 redirect_pc_i  in  PLEN  new fetch PC on redirect.
REQ-018 count_o  out  log2(DEPTH)+1  number of valid entries.

Function
REQ-019 Storage SHALL be a circular buffer with head/tail pointers of width log2(DEPTH)+1; empty = pointers equal, full = low bits equal and MSB different.
REQ-020 enq fire = enq_valid_i && enq_ready_o; enq_ready_o SHALL equal !full && !redirect_valid_i.
REQ-021 On enq fire the entry {fetch_pc_o, bpu_slot_*} SHALL be written at tail, tail incremented, and fetch_pc_o SHALL take bpu_npc_i on the next edge.
REQ-022 Without enq fire or redirect, fetch_pc_o SHALL hold.
REQ-023 deq_valid_o SHALL equal !empty && !redirect_valid_i; deq_* SHALL be driven from the head entry (no enqueue-to-dequeue bypass; minimum latency one cycle).
REQ-024 deq fire = deq_valid_o && deq_ready_i SHALL increment head; deq_* outputs SHALL be stable while deq_valid_o && !deq_ready_i.
REQ-025 Simultaneous enq fire and deq fire SHALL leave count_o unchanged; when full, enq_ready_o stays 0 in that cycle even if deq fires (no same-cycle pass-through).
REQ-026 Pointers SHALL wrap modulo 2*DEPTH; deq_ftq_idx_o wraps DEPTH-1 -> 0; FIFO order preserved across wrap.
REQ-027 redirect_valid_i SHALL take priority: next edge head=tail=0, count_o=0, fetch_pc_o=redirect_pc_i; concurrent enq/deq handshakes are suppressed by REQ-020/REQ-023.
REQ-028 Redirect on consecutive cycles SHALL each reload fetch_pc_o; the last value wins.
REQ-029 count_o SHALL equal tail minus head (width log2(DEPTH)+1), never exceeding DEPTH.
REQ-030 Entry storage contents need not be reset; no output shall depend on unwritten entries.

Reset
REQ-031 While rst_ni=0: fetch_pc_o=RESET_PC, head=tail=0, count_o=0, deq_valid_o=0, enq_ready_o=1 (with redirect low); deq_* data outputs are don't-care.
REQ-032 Reset assertion mid-operation SHALL discard all entries immediately, asynchronously; first enqueue after release uses fetch_pc_o=RESET_PC.

Verification
REQ-033 Reset release -> fetch_pc_o=0x8000_0000, count_o=0, deq_valid_o=0, enq_ready_o=1.
REQ-034 One enq with bpu_npc_i=0x8000_0010, slot_valid=1, idx=2 -> next cycle fetch_pc_o=0x8000_0010, deq_valid_o=1, deq_pc_o=0x8000_0000, deq_slot_idx_o=2, deq_ftq_idx_o=0.
REQ-035 8 enqueues, deq_ready_i=0 -> count_o=8, enq_ready_o=0, fetch_pc_o holds; one deq -> count_o=7, enq_ready_o=1 next cycle.
REQ-036 count_o=5, redirect_pc_i=0x8000_1234 with enq_valid_i and deq_ready_i high -> both handshakes 0 that cycle; next cycle count_o=0, fetch_pc_o=0x8000_1234.
REQ-037 20 cycles of simultaneous enq/deq at count_o=1 -> count_o stays 1, deq_pc_o sequence matches enqueue order, deq_ftq_idx_o wraps 7->0.
REQ-038 rst_ni pulsed low with count_o=6 between clock edges -> count_o=0, deq_valid_o=0, fetch_pc_o=0x8000_0000 before the next edge.

Source files
------------

// File: rtl/fetch_target_queue_if.sv
// Predictor/fetch-unit facing bundle of the fetch target queue.
// The queue sits on the slave side and the predictor/fetch environment on the master side.
interface fetch_target_queue_if #(
  parameter int unsigned PLEN       = 32,
  parameter int unsigned SLOT_IDX_W = 2,
  parameter int unsigned DEPTH      = 8
);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [PLEN-1:0]       fetch_pc_o;
  logic [PLEN-1:0]       bpu_npc_i;
  logic                  bpu_slot_valid_i;
  logic [SLOT_IDX_W-1:0] bpu_slot_idx_i;
  logic [PLEN-1:0]       bpu_slot_target_i;
  logic                  enq_valid_i;
  logic                  enq_ready_o;
  logic                  deq_valid_o;
  logic                  deq_ready_i;
  logic [PLEN-1:0]       deq_pc_o;
  logic                  deq_slot_valid_o;
  logic [SLOT_IDX_W-1:0] deq_slot_idx_o;
  logic [PLEN-1:0]       deq_slot_target_o;
  logic [IDX_W-1:0]      deq_ftq_idx_o;
  logic                  redirect_valid_i;
  logic [PLEN-1:0]       redirect_pc_i;
  logic [IDX_W:0]        count_o;

  modport slave (
    output fetch_pc_o, enq_ready_o, deq_valid_o, deq_pc_o, deq_slot_valid_o,
           deq_slot_idx_o, deq_slot_target_o, deq_ftq_idx_o, count_o,
    input  bpu_npc_i, bpu_slot_valid_i, bpu_slot_idx_i, bpu_slot_target_i,
           enq_valid_i, deq_ready_i, redirect_valid_i, redirect_pc_i
  );

  modport master (
    input  fetch_pc_o, enq_ready_o, deq_valid_o, deq_pc_o, deq_slot_valid_o,
           deq_slot_idx_o, deq_slot_target_o, deq_ftq_idx_o, count_o,
    output bpu_npc_i, bpu_slot_valid_i, bpu_slot_idx_i, bpu_slot_target_i,
           enq_valid_i, deq_ready_i, redirect_valid_i, redirect_pc_i
  );
endinterface

// File: rtl/fetch_target_queue.sv
// Fetch target queue: decouples branch-predictor output from the fetch unit and
// owns the fetch PC sequence (advance on accepted prediction, reload on redirect).
module fetch_target_queue #(
  parameter int unsigned     PLEN       = 32,
  parameter int unsigned     SLOT_IDX_W = 2,
  parameter int unsigned     DEPTH      = 8,
  parameter logic [PLEN-1:0] RESET_PC   = PLEN'(32'h8000_0000)
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  fetch_target_queue_if.slave  ftq
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  typedef struct packed {
    logic [PLEN-1:0]       pc;
    logic                  slot_valid;
    logic [SLOT_IDX_W-1:0] slot_idx;
    logic [PLEN-1:0]       slot_target;
  } entry_t;

  entry_t            mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [PLEN-1:0]   fetch_pc_q, fetch_pc_d;

  logic   full, empty;
  logic   enq_ready, deq_valid;
  logic   enq_fire, deq_fire;
  entry_t wr_entry;
  entry_t head_entry;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    full       = (tail_q[IDX_W-1:0] == head_q[IDX_W-1:0]) && (tail_q[IDX_W] != head_q[IDX_W]);
    empty      = (tail_q == head_q);
    // A redirect masks both handshakes so nothing is accepted or consumed
    // in the cycle the queue is being flushed.
    enq_ready  = !full && !ftq.redirect_valid_i;
    deq_valid  = !empty && !ftq.redirect_valid_i;
    enq_fire   = ftq.enq_valid_i && enq_ready;
    deq_fire   = deq_valid && ftq.deq_ready_i;

    wr_entry   = '{pc:          fetch_pc_q,
                   slot_valid:  ftq.bpu_slot_valid_i,
                   slot_idx:    ftq.bpu_slot_idx_i,
                   slot_target: ftq.bpu_slot_target_i};

    head_d     = head_q;
    tail_d     = tail_q;
    fetch_pc_d = fetch_pc_q;

    if (ftq.redirect_valid_i) begin
      head_d     = '0;
      tail_d     = '0;
      fetch_pc_d = ftq.redirect_pc_i;
    end else begin
      if (enq_fire) begin
        tail_d     = tail_q + PTR_W'(1);
        fetch_pc_d = ftq.bpu_npc_i;
      end
      if (deq_fire) begin
        head_d = head_q + PTR_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours regardless of process ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q     <= '0;
      tail_q     <= '0;
      fetch_pc_q <= RESET_PC;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // NOTE: entry storage is deliberately not reset; validity lives entirely in
  // the pointers, so stale contents are never observed through deq_valid_o.
  always_ff @(posedge clk_i) begin
    if (enq_fire) begin
      mem_q[tail_q[IDX_W-1:0]] <= wr_entry;
    end
  end

  assign head_entry            = mem_q[head_q[IDX_W-1:0]];

  assign ftq.fetch_pc_o        = fetch_pc_q;
  assign ftq.enq_ready_o       = enq_ready;
  assign ftq.deq_valid_o       = deq_valid;
  assign ftq.deq_pc_o          = head_entry.pc;
  assign ftq.deq_slot_valid_o  = head_entry.slot_valid;
  assign ftq.deq_slot_idx_o    = head_entry.slot_idx;
  assign ftq.deq_slot_target_o = head_entry.slot_target;
  assign ftq.deq_ftq_idx_o     = head_q[IDX_W-1:0];
  assign ftq.count_o           = tail_q - head_q;
endmodule

// File: tb/tb_fetch_target_queue.sv
// Directed self-checking bench for fetch_target_queue: reset, single enqueue,
// fill/backpressure, redirect flush, streaming wrap, and asynchronous reset.
module tb_fetch_target_queue;
  localparam int unsigned PLEN       = 32;
  localparam int unsigned SLOT_IDX_W = 2;
  localparam int unsigned DEPTH      = 8;
  localparam int unsigned IDX_W      = $clog2(DEPTH);

  typedef struct {
    logic [PLEN-1:0]       pc;
    logic                  sv;
    logic [SLOT_IDX_W-1:0] idx;
    logic [PLEN-1:0]       tgt;
  } exp_entry_t;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;

  fetch_target_queue_if #(.PLEN(PLEN), .SLOT_IDX_W(SLOT_IDX_W), .DEPTH(DEPTH)) ftq_if ();

  fetch_target_queue #(
    .PLEN(PLEN), .SLOT_IDX_W(SLOT_IDX_W), .DEPTH(DEPTH), .RESET_PC(32'h8000_0000)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .ftq    (ftq_if.slave)
  );

  always #5 clk_i = ~clk_i;

  int              n_checks = 0;
  int              n_errors = 0;
  exp_entry_t      exp_q[$];
  exp_entry_t      e;
  logic [PLEN-1:0] model_pc;
  int              prev_idx;
  logic            wrapped;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic set_bpu(input logic [PLEN-1:0] npc, input logic sv,
                         input logic [SLOT_IDX_W-1:0] idx, input logic [PLEN-1:0] tgt);
    ftq_if.bpu_npc_i         = npc;
    ftq_if.bpu_slot_valid_i  = sv;
    ftq_if.bpu_slot_idx_i    = idx;
    ftq_if.bpu_slot_target_i = tgt;
  endtask

  task automatic check_head(input string tag);
    check({tag, "_pc"},  ftq_if.deq_pc_o,          exp_q[0].pc);
    check({tag, "_sv"},  ftq_if.deq_slot_valid_o,  exp_q[0].sv);
    check({tag, "_idx"}, ftq_if.deq_slot_idx_o,    exp_q[0].idx);
    check({tag, "_tgt"}, ftq_if.deq_slot_target_o, exp_q[0].tgt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    set_bpu('0, 1'b0, '0, '0);
    ftq_if.enq_valid_i      = 1'b0;
    ftq_if.deq_ready_i      = 1'b0;
    ftq_if.redirect_valid_i = 1'b0;
    ftq_if.redirect_pc_i    = '0;

    // Reset held, then released between edges
    #12;
    check("rst_pc",      ftq_if.fetch_pc_o,  32'h8000_0000);
    check("rst_count",   ftq_if.count_o,     0);
    check("rst_dvalid",  ftq_if.deq_valid_o, 0);
    check("rst_erdy",    ftq_if.enq_ready_o, 1);
    rst_ni = 1'b1;
    tick();
    check("rel_pc",      ftq_if.fetch_pc_o,  32'h8000_0000);
    check("rel_count",   ftq_if.count_o,     0);
    check("rel_dvalid",  ftq_if.deq_valid_o, 0);
    check("rel_erdy",    ftq_if.enq_ready_o, 1);

    // Single enqueue, visible one cycle later
    set_bpu(32'h8000_0010, 1'b1, 2'd2, 32'h8000_0400);
    ftq_if.enq_valid_i = 1'b1;
    #1;
    check("one_erdy",    ftq_if.enq_ready_o, 1);
    check("one_nobyp",   ftq_if.deq_valid_o, 0);
    tick();
    ftq_if.enq_valid_i = 1'b0;
    #1;
    check("one_pc",      ftq_if.fetch_pc_o,        32'h8000_0010);
    check("one_dvalid",  ftq_if.deq_valid_o,       1);
    check("one_dpc",     ftq_if.deq_pc_o,          32'h8000_0000);
    check("one_dsv",     ftq_if.deq_slot_valid_o,  1);
    check("one_didx",    ftq_if.deq_slot_idx_o,    2);
    check("one_dtgt",    ftq_if.deq_slot_target_o, 32'h8000_0400);
    check("one_fidx",    ftq_if.deq_ftq_idx_o,     0);
    check("one_count",   ftq_if.count_o,           1);
    ftq_if.deq_ready_i = 1'b1;
    tick();
    ftq_if.deq_ready_i = 1'b0;
    #1;
    check("one_empty",   ftq_if.count_o,     0);
    check("one_edv",     ftq_if.deq_valid_o, 0);
    model_pc = 32'h8000_0010;

    // Fill to DEPTH with the consumer stalled (pointers start at 1)
    for (int i = 0; i < DEPTH; i++) begin
      set_bpu(model_pc + 32'h10, i[0], i[SLOT_IDX_W-1:0], 32'h9000_0000 + i);
      ftq_if.enq_valid_i = 1'b1;
      #1;
      check("fill_erdy", ftq_if.enq_ready_o, 1);
      e = '{pc: model_pc, sv: i[0], idx: i[SLOT_IDX_W-1:0], tgt: 32'h9000_0000 + i};
      exp_q.push_back(e);
      tick();
      model_pc = model_pc + 32'h10;
    end
    set_bpu(model_pc + 32'h10, 1'b0, '0, '0);
    #1;
    check("full_count",  ftq_if.count_o,     8);
    check("full_erdy",   ftq_if.enq_ready_o, 0);
    check("full_dvalid", ftq_if.deq_valid_o, 1);
    tick();
    check("full_hold",   ftq_if.fetch_pc_o,    model_pc);
    check("full_cnt2",   ftq_if.count_o,       8);
    check("full_fidx",   ftq_if.deq_ftq_idx_o, 1);
    check_head("full_head");
    // Dequeue while full: no same-cycle pass-through
    ftq_if.deq_ready_i = 1'b1;
    #1;
    check("full_nopass", ftq_if.enq_ready_o, 0);
    tick();
    void'(exp_q.pop_front());
    ftq_if.enq_valid_i = 1'b0;
    ftq_if.deq_ready_i = 1'b0;
    #1;
    check("deq1_count",  ftq_if.count_o,     7);
    check("deq1_erdy",   ftq_if.enq_ready_o, 1);
    check("deq1_pc",     ftq_if.fetch_pc_o,  model_pc);
    for (int k = 0; k < 2; k++) begin
      ftq_if.deq_ready_i = 1'b1;
      #1;
      check_head("drain");
      tick();
      void'(exp_q.pop_front());
    end
    ftq_if.deq_ready_i = 1'b0;
    #1;
    check("pre_redir_cnt", ftq_if.count_o, 5);
    check_head("stall_head");

    // Redirect with both handshakes requested
    ftq_if.redirect_valid_i = 1'b1;
    ftq_if.redirect_pc_i    = 32'h8000_1234;
    ftq_if.enq_valid_i      = 1'b1;
    ftq_if.deq_ready_i      = 1'b1;
    #1;
    check("redir_erdy",   ftq_if.enq_ready_o, 0);
    check("redir_dvalid", ftq_if.deq_valid_o, 0);
    tick();
    ftq_if.redirect_valid_i = 1'b0;
    ftq_if.enq_valid_i      = 1'b0;
    ftq_if.deq_ready_i      = 1'b0;
    #1;
    check("redir_count",  ftq_if.count_o,     0);
    check("redir_pc",     ftq_if.fetch_pc_o,  32'h8000_1234);
    check("redir_dv2",    ftq_if.deq_valid_o, 0);
    exp_q.delete();

    // Back-to-back redirects: last one wins
    ftq_if.redirect_valid_i = 1'b1;
    ftq_if.redirect_pc_i    = 32'h8000_2000;
    tick();
    ftq_if.redirect_pc_i    = 32'h8000_3000;
    tick();
    ftq_if.redirect_valid_i = 1'b0;
    #1;
    check("redir2_pc",    ftq_if.fetch_pc_o, 32'h8000_3000);
    check("redir2_count", ftq_if.count_o,    0);
    model_pc = 32'h8000_3000;

    // Prime one entry, then stream 20 cycles of simultaneous enq/deq
    set_bpu(model_pc + 32'h10, 1'b1, 2'd3, 32'hA000_0000);
    ftq_if.enq_valid_i = 1'b1;
    e = '{pc: model_pc, sv: 1'b1, idx: 2'd3, tgt: 32'hA000_0000};
    exp_q.push_back(e);
    tick();
    model_pc = model_pc + 32'h10;
    prev_idx = -1;
    wrapped  = 1'b0;
    for (int c = 0; c < 20; c++) begin
      set_bpu(model_pc + 32'h10, c[0], c[SLOT_IDX_W-1:0], 32'hA000_0100 + c);
      ftq_if.enq_valid_i = 1'b1;
      ftq_if.deq_ready_i = 1'b1;
      #1;
      check("strm_count",  ftq_if.count_o,       1);
      check("strm_fidx",   ftq_if.deq_ftq_idx_o, c % DEPTH);
      check("strm_dpc",    ftq_if.deq_pc_o,      exp_q[0].pc);
      check("strm_dtgt",   ftq_if.deq_slot_target_o, exp_q[0].tgt);
      if (prev_idx == DEPTH - 1 && ftq_if.deq_ftq_idx_o == '0) wrapped = 1'b1;
      prev_idx = int'(ftq_if.deq_ftq_idx_o);
      e = '{pc: model_pc, sv: c[0], idx: c[SLOT_IDX_W-1:0], tgt: 32'hA000_0100 + c};
      exp_q.push_back(e);
      tick();
      void'(exp_q.pop_front());
      model_pc = model_pc + 32'h10;
    end
    ftq_if.enq_valid_i = 1'b0;
    ftq_if.deq_ready_i = 1'b0;
    #1;
    check("strm_end_cnt", ftq_if.count_o, 1);
    check("strm_wrap",    wrapped,        1);
    check_head("strm_head");
    check("strm_pc",      ftq_if.fetch_pc_o, model_pc);

    // Grow to six entries, then pulse reset between edges
    for (int i = 0; i < 5; i++) begin
      set_bpu(model_pc + 32'h10, 1'b0, '0, '0);
      ftq_if.enq_valid_i = 1'b1;
      tick();
      model_pc = model_pc + 32'h10;
    end
    ftq_if.enq_valid_i = 1'b0;
    #1;
    check("pre_rst_cnt",  ftq_if.count_o, 6);
    rst_ni = 1'b0;
    #1;
    check("arst_count",   ftq_if.count_o,     0);
    check("arst_dvalid",  ftq_if.deq_valid_o, 0);
    check("arst_pc",      ftq_if.fetch_pc_o,  32'h8000_0000);
    rst_ni = 1'b1;
    tick();
    set_bpu(32'h8000_0020, 1'b0, 2'd1, 32'hB000_0000);
    ftq_if.enq_valid_i = 1'b1;
    tick();
    ftq_if.enq_valid_i = 1'b0;
    #1;
    check("post_rst_dpc", ftq_if.deq_pc_o,   32'h8000_0000);
    check("post_rst_pc",  ftq_if.fetch_pc_o, 32'h8000_0020);
    check("post_rst_cnt", ftq_if.count_o,    1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
